regfile_wport_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline WB stage and the multi-cycle multiply/divide unit (MDU), and keeps a scoreboard of registers with outstanding MDU results. Sits between the WB stage, the MDU and the register file write port (regWrite/wn/wd). It also supplies the ID-stage stall for operands not yet written back.

---
 rtl/regfile_wport_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter between the WB stage and the MDU result FIFO, with a
// scoreboard of registers that still have an MDU result outstanding.
module regfile_wport_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_wn,
   input  logic [31:0] wb_wd,
   output logic        wb_hold,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_wn,
   input  logic [31:0] mdu_wd,
   output logic        mdu_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_wn,
   output logic        issue_ok,
   input  logic [4:0]  rn1,
   input  logic [4:0]  rn2,
   output logic        stall,
   output logic        regWrite,
   output logic [4:0]  wn,
   output logic [31:0] wd,
   output logic        err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [31:0]   pending;
   logic [31:0]   pending_nxt;
   logic [4:0]    fifo_wn [FIFO_DEPTH];
   logic [31:0]   fifo_wd [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_nxt;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          wb_grant;
   logic          issue_set;
   logic [4:0]    head_wn;
   logic [31:0]   head_wd;

   // Port grant: a pending forced drain beats WB, WB beats a normal drain.
   // Nothing is written while rst is high.
   always_comb begin
      fifo_empty = (count == '0);
      mdu_ready  = (count < (AW+1)'(FIFO_DEPTH));
      push       = mdu_valid && mdu_ready;
      head_wn    = fifo_wn[rd_ptr];
      head_wd    = fifo_wd[rd_ptr];
      wb_grant   = 1'b0;
      pop        = 1'b0;
      if (!rst) begin
         if (wb_hold)
            pop = !fifo_empty;
         else if (wb_valid && (wb_wn != 5'd0))
            wb_grant = 1'b1;
         else
            pop = !fifo_empty;
      end
      regWrite = wb_grant | pop;
      wn       = wb_grant ? wb_wn : head_wn;
      wd       = wb_grant ? wb_wd : head_wd;
   end

   // Scoreboard lookups use the current state, so a same-cycle clear never
   // makes a register look free to a new issue.
   always_comb begin
      issue_ok    = !pending[issue_wn];
      issue_set   = issue_valid && issue_ok && (issue_wn != 5'd0);
      stall       = pending[rn1] | pending[rn2];
      pending_nxt = pending;
      if (pop)
         pending_nxt[head_wn] = 1'b0;
      if (issue_set)
         pending_nxt[issue_wn] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (pop || fifo_empty)
         starve_nxt = '0;
      else if (wb_grant)
         starve_nxt = starve_cnt + 1'b1;
   end

   // Control state; wb_hold is flopped from the next counter value so it is
   // high exactly in the cycle the counter sits at STARVE_MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         wb_hold    <= 1'b0;
         err        <= 1'b0;
      end else begin
         pending    <= pending_nxt;
         starve_cnt <= starve_nxt;
         wb_hold    <= (starve_nxt == SW'(STARVE_MAX));
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (wb_grant && pending[wb_wn])
            err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         fifo_wn[wr_ptr] <= mdu_wn;
         fifo_wd[wr_ptr] <= mdu_wd;
      end
   end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: scoreboard timing, starvation
// forcing, FIFO full behaviour, WAW error and mid-operation reset.
module tb_regfile_wport_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_wn;
   logic [31:0] wb_wd;
   logic        wb_hold;
   logic        mdu_valid;
   logic [4:0]  mdu_wn;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_wn;
   logic        issue_ok;
   logic [4:0]  rn1;
   logic [4:0]  rn2;
   logic        stall;
   logic        regWrite;
   logic [4:0]  wn;
   logic [31:0] wd;
   logic        err;

   int checks = 0;
   int errors = 0;

   regfile_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_wn(wb_wn), .wb_wd(wb_wd), .wb_hold(wb_hold),
      .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
      .issue_valid(issue_valid), .issue_wn(issue_wn), .issue_ok(issue_ok),
      .rn1(rn1), .rn2(rn2), .stall(stall),
      .regWrite(regWrite), .wn(wn), .wd(wd), .err(err)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the WB and MDU inputs for this cycle, then let outputs settle.
   task automatic applyStimulus(input logic wv, input logic [4:0] wnn, input logic [31:0] wdd,
                                input logic mv, input logic [4:0] mn, input logic [31:0] md);
      wb_valid  = wv;
      wb_wn     = wnn;
      wb_wd     = wdd;
      mdu_valid = mv;
      mdu_wn    = mn;
      mdu_wd    = md;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      issue_valid = 1'b0;
      issue_wn = 5'd0;
      rn1 = 5'd0;
      rn2 = 5'd0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_wb_hold", {31'd0, wb_hold}, 32'd0);
      checkOutput("rst_err", {31'd0, err}, 32'd0);
      checkOutput("rst_regWrite", {31'd0, regWrite}, 32'd0);
      checkOutput("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
      checkOutput("rst_stall", {31'd0, stall}, 32'd0);
      checkOutput("rst_issue_ok", {31'd0, issue_ok}, 32'd1);

      // Issue r5, result comes back with WB idle.
      $display("[TB] issue r5 and write back");
      issue_valid = 1'b1;
      issue_wn = 5'd5;
      rn1 = 5'd5;
      #1;
      checkOutput("t1_issue_ok", {31'd0, issue_ok}, 32'd1);
      checkOutput("t1_stall_pre", {31'd0, stall}, 32'd0);
      tick();
      issue_valid = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678);
      checkOutput("t1_stall_set", {31'd0, stall}, 32'd1);
      checkOutput("t1_issue_ok_busy", {31'd0, issue_ok}, 32'd0);
      checkOutput("t1_no_bypass", {31'd0, regWrite}, 32'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("t1_wr_en", {31'd0, regWrite}, 32'd1);
      checkOutput("t1_wr_wn", {27'd0, wn}, 32'd5);
      checkOutput("t1_wr_wd", wd, 32'h12345678);
      checkOutput("t1_stall_popcyc", {31'd0, stall}, 32'd1);
      tick();
      checkOutput("t1_stall_clear", {31'd0, stall}, 32'd0);
      checkOutput("t1_idle", {31'd0, regWrite}, 32'd0);
      rn1 = 5'd0;

      // WB busy on r3 while r9 waits in the FIFO.
      $display("[TB] starvation forcing");
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd9, 32'hAA);
      checkOutput("t2_c0_wn", {27'd0, wn}, 32'd3);
      for (int c = 1; c <= 4; c++) begin
         tick();
         applyStimulus(1'b1, 5'd3, 32'd7, 1'b0, 5'd0, 32'd0);
         checkOutput($sformatf("t2_c%0d_hold", c), {31'd0, wb_hold}, 32'd0);
         checkOutput($sformatf("t2_c%0d_wn", c), {27'd0, wn}, 32'd3);
      end
      tick();
      checkOutput("t2_hold", {31'd0, wb_hold}, 32'd1);
      checkOutput("t2_force_en", {31'd0, regWrite}, 32'd1);
      checkOutput("t2_force_wn", {27'd0, wn}, 32'd9);
      checkOutput("t2_force_wd", wd, 32'hAA);
      tick();
      checkOutput("t2_after_hold", {31'd0, wb_hold}, 32'd0);
      checkOutput("t2_after_wn", {27'd0, wn}, 32'd3);
      checkOutput("t2_after_wd", wd, 32'd7);

      // Fill the FIFO while WB is busy, then drain.
      $display("[TB] FIFO full and drain order");
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd10, 32'h10);
      checkOutput("t3_ready0", {31'd0, mdu_ready}, 32'd1);
      tick();
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd11, 32'h11);
      checkOutput("t3_ready1", {31'd0, mdu_ready}, 32'd1);
      tick();
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd12, 32'h12);
      checkOutput("t3_full", {31'd0, mdu_ready}, 32'd0);
      checkOutput("t3_wb_wn", {27'd0, wn}, 32'd3);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("t3_d0_wn", {27'd0, wn}, 32'd10);
      checkOutput("t3_d0_wd", wd, 32'h10);
      tick();
      checkOutput("t3_d1_ready", {31'd0, mdu_ready}, 32'd1);
      checkOutput("t3_d1_wn", {27'd0, wn}, 32'd11);
      checkOutput("t3_d1_wd", wd, 32'h11);
      tick();
      checkOutput("t3_third_dropped", {31'd0, regWrite}, 32'd0);

      // Double issue to r4.
      $display("[TB] double issue r4");
      issue_valid = 1'b1;
      issue_wn = 5'd4;
      #1;
      checkOutput("t4_first_ok", {31'd0, issue_ok}, 32'd1);
      tick();
      checkOutput("t4_second_ok", {31'd0, issue_ok}, 32'd0);
      tick();
      issue_valid = 1'b0;
      rn2 = 5'd4;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
      checkOutput("t4_still_pending", {31'd0, stall}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("t4_wb_wn", {27'd0, wn}, 32'd4);
      checkOutput("t4_ok_popcyc", {31'd0, issue_ok}, 32'd0);
      tick();
      checkOutput("t4_ok_after", {31'd0, issue_ok}, 32'd1);
      rn2 = 5'd0;

      // WAW: WB writes a pending register.
      $display("[TB] WAW error");
      issue_valid = 1'b1;
      issue_wn = 5'd6;
      tick();
      issue_valid = 1'b0;
      applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
      checkOutput("t5_err_pre", {31'd0, err}, 32'd0);
      checkOutput("t5_wb_wr", {27'd0, wn}, 32'd6);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("t5_err_set", {31'd0, err}, 32'd1);
      tick();
      tick();
      checkOutput("t5_err_sticky", {31'd0, err}, 32'd1);

      // Reset with a full FIFO and r2/r7 pending.
      $display("[TB] reset mid-operation");
      issue_valid = 1'b1;
      issue_wn = 5'd2;
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd2, 32'h22);
      tick();
      issue_wn = 5'd7;
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd7, 32'h77);
      tick();
      issue_valid = 1'b0;
      rn1 = 5'd2;
      rn2 = 5'd7;
      applyStimulus(1'b1, 5'd3, 32'd7, 1'b0, 5'd0, 32'd0);
      checkOutput("t6_full", {31'd0, mdu_ready}, 32'd0);
      checkOutput("t6_stall_pre", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_nowrite", {31'd0, regWrite}, 32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("t6_ready", {31'd0, mdu_ready}, 32'd1);
      checkOutput("t6_stall", {31'd0, stall}, 32'd0);
      checkOutput("t6_err", {31'd0, err}, 32'd0);
      checkOutput("t6_nowrite", {31'd0, regWrite}, 32'd0);
      tick();
      checkOutput("t6_nowrite2", {31'd0, regWrite}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
